// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle MIPS EX-stage ALU (iterative MUL/DIV)
// Optional macro ULA_OVERFLOW_EN adds the registered overflow output.
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [3:0]       controle_ULA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] saida,
  output logic [WIDTH-1:0] resto,
`ifdef ULA_OVERFLOW_EN
  output logic             ZERO,
  output logic             overflow
`else
  output logic             ZERO
`endif
);

`ifdef ULA_OVERFLOW_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [AW-1:0]    r_x;
  logic [WIDTH-1:0] r_b;
  logic [AW-1:0]    r_acc;
  logic [WIDTH:0]   r_rem;
  logic [SHW-1:0]   r_cnt;

  logic             w_accept, w_last, w_ge;
  logic [WIDTH-1:0] w_alu, w_q_next;
  logic [AW-1:0]    w_acc_next;
  logic [WIDTH:0]   w_rem_sh, w_rem_next;

  assign w_accept = (r_state == S_IDLE) && start && enable;
  assign w_last   = (r_cnt == SHW'(WIDTH - 1));

  always_comb begin
    w_alu = '0;
    case (controle_ULA)
      4'b0000: w_alu = A & B;
      4'b0001: w_alu = A | B;
      4'b0010: w_alu = A + B;
      4'b0011: w_alu = A - B;
      4'b0110: w_alu = A >> B[SHW-1:0];
      4'b0111: w_alu = A << B[SHW-1:0];
      4'b1000: w_alu = ~(A | B);
      4'b1001: w_alu = (A == B) ? '0 : WIDTH'(1);
      4'b1010: w_alu = (A <  B) ? '0 : WIDTH'(1);
      4'b1011: w_alu = (A >  B) ? '0 : WIDTH'(1);
      4'b1100: w_alu = (A != B) ? '0 : WIDTH'(1);
      4'b1101: w_alu = (A <  B) ? WIDTH'(1) : '0;
      4'b1110: w_alu = (A >  B) ? WIDTH'(1) : '0;
      default: w_alu = '0;
    endcase
  end

`ifdef ULA_OVERFLOW_EN
  logic [WIDTH:0] w_sum;
  logic           w_alu_ovf;
  always_comb begin
    w_sum     = {1'b0, A} + {1'b0, B};
    w_alu_ovf = 1'b0;
    if (controle_ULA == 4'b0010)      w_alu_ovf = w_sum[WIDTH];
    else if (controle_ULA == 4'b0011) w_alu_ovf = (A < B);
  end
`endif

  // Shift-add: multiplicand moves left, multiplier right, one bit per cycle.
  assign w_acc_next = r_b[0] ? (r_acc + r_x) : r_acc;

  // Restoring division; a zero divisor naturally yields all-ones and resto=A.
  assign w_rem_sh   = {r_rem[WIDTH-1:0], r_x[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_next = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
  assign w_q_next   = {r_x[WIDTH-2:0], w_ge};

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (controle_ULA == 4'b0100)      w_next = S_MUL;
          else if (controle_ULA == 4'b0101) w_next = S_DIV;
          else                              w_next = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (!enable)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      saida <= '0;
      resto <= '0;
      ZERO  <= 1'b0;
      r_x   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_cnt <= '0;
`ifdef ULA_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else if (r_state != S_IDLE && !enable) begin
      saida <= '0;
      resto <= '0;
      ZERO  <= 1'b0;
`ifdef ULA_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x   <= AW'(A);
            r_b   <= B;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            if (controle_ULA != 4'b0100 && controle_ULA != 4'b0101) begin
              saida <= w_alu;
              resto <= '0;
              ZERO  <= (w_alu == '0);
`ifdef ULA_OVERFLOW_EN
              overflow <= w_alu_ovf;
`endif
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_x   <= {r_x[AW-2:0], 1'b0};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            saida <= w_acc_next[WIDTH-1:0];
            resto <= '0;
            ZERO  <= (w_acc_next[WIDTH-1:0] == '0);
`ifdef ULA_OVERFLOW_EN
            overflow <= |w_acc_next[AW-1:WIDTH];
`endif
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_x   <= AW'(w_q_next);
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            saida <= w_q_next;
            resto <= w_rem_next[WIDTH-1:0];
            ZERO  <= (w_q_next == '0);
`ifdef ULA_OVERFLOW_EN
            overflow <= (r_b == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - scoreboard bench for ula_multiciclo
module tb_ula_multiciclo;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, enable, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero;
  logic [W-1:0] saida, resto;
`ifdef ULA_OVERFLOW_EN
  logic         overflow;
`endif

  ula_multiciclo #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .controle_ULA(op), .A(a), .B(b),
    .busy(busy), .done(done), .saida(saida), .resto(resto),
`ifdef ULA_OVERFLOW_EN
    .ZERO(zero), .overflow(overflow)
`else
    .ZERO(zero)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           c;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.c));
        check("saida", saida, mon_e.s);
        check("resto", resto, mon_e.r);
        check("ZERO", zero, mon_e.z);
`ifdef ULA_OVERFLOW_EN
        check("overflow", overflow, mon_e.o);
`endif
      end
    end
  end

  // Called at a negedge; waits for IDLE, presents start for 'hold' cycles.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] es, input logic [W-1:0] er, input logic eo,
                       input bit push, input int hold);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL idle_timeout: busy stuck for %0d cycles, required idle", n);
    end
    op = o; a = x; b = y; start = 1'b1;
    if (push)
      sb.push_back('{cyc + 1 + ((o == 4'b0100 || o == 4'b0101) ? W : 0), es, er, (es == '0), eo});
    repeat (hold) @(negedge clock);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  initial begin
    int n;
    reset = 1'b0; enable = 1'b1; start = 1'b0; op = 4'b0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_saida", saida, 0);
    check("rst_resto", resto, 0);
    check("rst_zero", zero, 0);
    reset = 1'b1;
    @(negedge clock);

    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b1, 1, 1);
    issue(4'b0011, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0, 1'b1, 1, 1);
    // start held into the DONE cycle must not be accepted twice
    issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'h0, 1'b0, 1, 2);

    issue(4'b0100, 32'd7, 32'd6, 32'd42, 32'h0, 1'b0, 1, 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      start = (n == 5 || n == 10) ? 1'b1 : 1'b0;
      op = 4'b0001;
      n++;
      @(negedge clock);
    end
    start = 1'b0;
    check("mul_busy_cycles", 64'(n), 64'd33);

    issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1, 1);
    issue(4'b0101, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1, 1);
    issue(4'b0101, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1);
    issue(4'b0101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1, 1);

    issue(4'b1001, 32'd3, 32'd5, 32'd1, 32'h0, 1'b0, 1, 1);
    issue(4'b1010, 32'd3, 32'd5, 32'd0, 32'h0, 1'b0, 1, 1);
    issue(4'b1011, 32'd3, 32'd5, 32'd1, 32'h0, 1'b0, 1, 1);
    issue(4'b1100, 32'd3, 32'd5, 32'd0, 32'h0, 1'b0, 1, 1);
    issue(4'b1101, 32'd3, 32'd5, 32'd1, 32'h0, 1'b0, 1, 1);
    issue(4'b1110, 32'd3, 32'd5, 32'd0, 32'h0, 1'b0, 1, 1);
    issue(4'b1000, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0, 1'b0, 1, 1);
    issue(4'b1111, 32'h1234_5678, 32'h1, 32'h0, 32'h0, 1'b0, 1, 1);
    issue(4'b0110, 32'h8000_0000, 32'h21, 32'h4000_0000, 32'h0, 1'b0, 1, 1);

    // reset while a MUL is in flight: result discarded
    issue(4'b0100, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 0, 1);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_saida", saida, 0);
    check("midrst_zero", zero, 0);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    // abort a DIV at iteration 10 by dropping enable
    issue(4'b0111, 32'd1, 32'd31, 32'h8000_0000, 32'h0, 1'b0, 1, 1);
    issue(4'b0101, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, 0, 1);
    repeat (10) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_saida", saida, 0);
    check("abort_resto", resto, 0);
    check("abort_zero", zero, 0);
    enable = 1'b1;
    repeat (40) @(negedge clock);
    issue(4'b0001, 32'hF0, 32'h0F, 32'hFF, 32'h0, 1'b0, 1, 1);
    @(negedge clock);

    // enable low in IDLE: start ignored, outputs hold
    enable = 1'b0; start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    check("noen_busy", busy, 0);
    check("noen_saida", saida, 32'hFF);
    enable = 1'b1;

    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected results never arrived, required 0", sb.size());
    end
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised multi-cycle successor to the datapath ALU for the MIPS processor: same 4-bit operation encoding, configurable operand width.
- AND/OR/ADD/SUB/shift/NOR/compare ops complete in one cycle.
- MUL (iterative shift-add) and DIV (iterative restoring) take WIDTH cycles, so the combinational multiplier/divider leaves the critical path.
- Sits in the EX stage. The control unit stalls on busy and consumes a one-cycle done pulse.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of two).
SHW, $clog2(WIDTH), shift-amount bits taken from B (derived, do not override).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
enable  input  1  ~NOP; low aborts/blocks operation.
start  input  1  request; sampled only in IDLE with enable=1.
controle_ULA  input  4  operation code (latched at start).
A  input  WIDTH  operand A (latched at start).
B  input  WIDTH  operand B (latched at start).
busy  output  1  high while an accepted operation is in flight.
done  output  1  one-cycle pulse: saida/resto/ZERO valid.
saida  output  WIDTH  result, held until next accepted start.
resto  output  WIDTH  DIV remainder; 0 for all other ops.
ZERO  output  1  saida==0, registered with saida.

Behaviour:
- Reset (reset=0 at rising edge): state=IDLE; busy=0, done=0, saida=0, resto=0, ZERO=0. Applies mid-operation; the in-flight op is discarded, no done.
- States:
  - IDLE: accept when start=1 && enable=1. Latch op, A, B. Single-cycle ops go to DONE. 0100 goes to MUL, 0101 goes to DIV. Undefined codes (1111) go to DONE with saida=0.
  - MUL/DIV: iteration counter runs 0..WIDTH-1, one bit per cycle. Go to DONE after the last iteration.
  - DONE: registers updated. done=1 for exactly this cycle. Return to IDLE.
- busy=1 in MUL, DIV and DONE. start is ignored while busy (no queueing).
- Latency (start accepted at edge k): single-cycle ops, done high during cycle k+1. MUL/DIV, done high during cycle k+WIDTH+1.
- Back-to-back: a start presented in the DONE cycle is ignored. Accept occurs at the next IDLE cycle, so throughput is at most one op per 2 cycles.
- Op codes (unsigned, WIDTH-bit, results truncated to WIDTH):
  - 0000 A&B; 0001 A|B; 0010 A+B; 0011 A-B (wraps modulo 2^WIDTH).
  - 0100 low WIDTH bits of A*B.
  - 0101 A/B, resto=A%B.
  - 0110 A>>B[SHW-1:0]; 0111 A<<B[SHW-1:0]; 1000 ~(A|B).
  - 1001 (A==B)?0:1; 1010 (A<B)?0:1; 1011 (A>B)?0:1; 1100 (A!=B)?0:1.
  - 1101 (A<B)?1:0; 1110 (A>B)?1:0.
- Divide by zero: saida=all ones, resto=A. Completes in normal DIV latency, no special flag.
- ZERO = (saida==0), computed from the new saida in the same update.
- enable=0 while IDLE: start ignored, outputs hold.
- enable=0 while MUL/DIV/DONE: abort to IDLE next edge. busy=0, done=0, saida=0, resto=0, ZERO=0.
- Operand inputs may change after acceptance without affecting the result.

Optional Feature:
ULA_OVERFLOW_EN
- Defined: adds output overflow (1 bit), registered with saida, valid on done.
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (A<B).
  - MUL: any nonzero bit in the upper WIDTH bits of the full 2*WIDTH product.
  - DIV: 1 on divide by zero.
  - All other ops: 0.
  - Reset/abort value: 0.
  - MUL keeps a 2*WIDTH accumulator.
- Undefined: no port, WIDTH-bit MUL accumulator only. All other behaviour identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles during a MUL in flight -> busy=0, done=0, saida=0, ZERO=0; no done pulse afterwards.
- WIDTH=32, op 0010, A=0xFFFFFFFF, B=1, start at edge k -> done at k+1, saida=0, ZERO=1. With ULA_OVERFLOW_EN: overflow=1.
- Op 0100, A=7, B=6 -> busy for 33 cycles, done at k+33, saida=42, resto=0. start pulses during busy are ignored.
- Op 0101, A=100, B=7 -> saida=14, resto=2. Then A=5, B=0 -> saida=0xFFFFFFFF, resto=5.
- Compare sweep A=3, B=5 -> 1001:1, 1010:0, 1011:1, 1100:0, 1101:1, 1110:0. Op 0110 with A=0x80000000, B=0x21 -> saida=0x40000000 (shift by 1).
- DIV in flight, drop enable at iteration 10 -> IDLE next edge, outputs 0, no done. Re-enable, start op 0001 A=0xF0, B=0x0F -> saida=0xFF.
